alu_sequencer: RTL

- Registered command front-end for the team's 16-bit combinational ALU breadboard (opcodes 1=ADD, 2=SUB, 3=MULT, 4=DIV, 5=MOD; 32-bit C; 2-bit error).
- Accepts commands over a valid/ready handshake and drives the ALU operand/opcode inputs from registers.
- Waits a programmable settle time, then captures C and error, and returns them over a valid/ready response channel.
- Also maintains an accumulator, sticky error flags and a completed-operation counter.

---
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Registered command front-end for the 16-bit combinational ALU breadboard.
// Holds operands for a programmable settle time, captures C/error, returns them over valid/ready.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          ACC_ON_ERROR  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_use_acc,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_c,
  input  logic [1:0]  alu_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_c,
  output logic [1:0]  rsp_error,
  output logic [31:0] acc,
  output logic [1:0]  err_sticky,
  input  logic        clr_sticky,
  output logic [15:0] op_count,
  output logic        busy
);

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 32;
  localparam int unsigned OPW  = 4;
  localparam int unsigned EW   = 2;
  localparam int unsigned CNTW = 4;

  localparam logic [OPW-1:0] OP_ADD      = OPW'(1);
  localparam logic [OPW-1:0] OP_MOD      = OPW'(5);
  localparam logic [EW-1:0]  ERR_ILLEGAL = EW'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [DW-1:0]   alu_a_q;
  logic [DW-1:0]   alu_b_q;
  logic [OPW-1:0]  alu_op_q;
  logic            rsp_valid_q;
  logic [CW-1:0]   rsp_c_q;
  logic [EW-1:0]   rsp_err_q;
  logic [CW-1:0]   acc_q;
  logic [EW-1:0]   sticky_q;
  logic [EW-1:0]   sticky_d;
  logic [DW-1:0]   count_q;
  logic            cmd_ready_q;
  logic            busy_q;

  logic            legal_op_c;
  logic            illegal_cap_c;
  logic            exec_cap_c;
  logic            capture_c;
  logic [EW-1:0]   cap_err_c;
  logic            acc_upd_c;

  // Capture qualifiers shared by the illegal-opcode path and the end of EXEC.
  always_comb begin
    legal_op_c    = (cmd_opcode >= OP_ADD) && (cmd_opcode <= OP_MOD);
    illegal_cap_c = (state_q == S_IDLE) && cmd_valid && !legal_op_c;
    exec_cap_c    = (state_q == S_EXEC) && (cnt_q == CNTW'(1));
    capture_c     = illegal_cap_c || exec_cap_c;
    cap_err_c     = illegal_cap_c ? ERR_ILLEGAL : alu_error;
    acc_upd_c     = exec_cap_c && ((alu_error == '0) || ACC_ON_ERROR);
    // A clear on a capture edge still keeps the freshly captured error.
    sticky_d      = (clr_sticky ? '0 : sticky_q) | (capture_c ? cap_err_c : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_err_q   <= '0;
      acc_q       <= '0;
      sticky_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      if (acc_upd_c) begin
        acc_q <= alu_c;
      end
      if (capture_c) begin
        rsp_c_q     <= illegal_cap_c ? '0 : alu_c;
        rsp_err_q   <= cap_err_c;
        rsp_valid_q <= 1'b1;
        count_q     <= count_q + DW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (legal_op_c) begin
              alu_op_q <= cmd_opcode;
              alu_b_q  <= cmd_b;
              alu_a_q  <= cmd_use_acc ? acc_q[DW-1:0] : cmd_a;
              cnt_q    <= CNTW'(SETTLE_CYCLES);
              state_q  <= S_EXEC;
            end else begin
              state_q  <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          cnt_q <= cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // A pending response must stay put until the consumer takes it.
  assert property (@(posedge clk) disable iff (rst)
    (rsp_valid_q && !rsp_ready) |=> (rsp_valid_q && $stable(rsp_c_q) && $stable(rsp_err_q)));

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_error  = rsp_err_q;
  assign acc        = acc_q;
  assign err_sticky = sticky_q;
  assign op_count   = count_q;

endmodule
